// File: rtl/stopwatch_lap_ctrl_if.sv
// Button and status bundle between the stopwatch panel and the lap/split controller.
// The master drives the raw button levels; the slave (controller) returns slot enables and display control.
interface stopwatch_lap_ctrl_if #(
  parameter int N_SLOTS = 10,
  parameter int SEL_W   = 4
);
  logic                   startstop;
  logic                   mark;
  logic                   pause;
  logic                   clear;
  logic                   mode;
  logic [N_SLOTS:0]       en;
  logic [2*N_SLOTS-1:0]   running;
  logic [SEL_W-1:0]       disp_sel;
  logic                   disp_update;
  logic                   full;

  modport master (
    output startstop, mark, pause, clear, mode,
    input  en, running, disp_sel, disp_update, full
  );

  modport slave (
    input  startstop, mark, pause, clear, mode,
    output en, running, disp_sel, disp_update, full
  );
endinterface

// File: rtl/stopwatch_lap_ctrl.sv
// Control FSM for an N-slot split/lap stopwatch: synchronises the buttons, runs IDLE/RUN/STOP
// and drives slot counter enables, per-slot status and display selection/freeze.
module stopwatch_lap_ctrl #(
  parameter int N_SLOTS     = 10,
  parameter int SEL_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  n_reset,
  stopwatch_lap_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [SEL_W-1:0]       LAST        = SEL_W'(N_SLOTS - 1);
  localparam logic [2*N_SLOTS-1:0]   SPLIT_START = {N_SLOTS{2'b01}};
  localparam logic [2*N_SLOTS-1:0]   LAP_START   = {{(2*N_SLOTS-2){1'b0}}, 2'b01};

  // Button order in the vectors below: {clear, startstop, mark, pause}.
  logic [3:0]                  btn;
  logic [3:0][SYNC_STAGES-1:0] sync_q;
  logic [3:0]                  prev_q;
  logic [3:0]                  rise;
  logic                        clear_e, ss_e, mark_e, pause_e;

  state_t                  state_q;
  logic [SEL_W-1:0]        cur_q;
  logic [SEL_W-1:0]        nxt_cur;
  logic [SEL_W-1:0]        disp_sel_q;
  logic                    mode_q;
  logic [N_SLOTS:0]        en_q;
  logic [2*N_SLOTS-1:0]    running_q;
  logic                    disp_update_q;
  logic                    full_q;

  assign btn     = {bus.clear, bus.startstop, bus.mark, bus.pause};
  assign rise    = ~prev_q & {sync_q[3][SYNC_STAGES-1], sync_q[2][SYNC_STAGES-1],
                              sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
  assign clear_e = rise[3];
  assign ss_e    = rise[2];
  assign mark_e  = rise[1];
  assign pause_e = rise[0];
  assign nxt_cur = cur_q + 1'b1;

  // Enables while running: SPLIT counts every slot from cur upward, LAP only slot cur.
  function automatic logic [N_SLOTS:0] run_en(input logic [SEL_W-1:0] c, input logic lap);
    logic [N_SLOTS:0] e;
    // NOTE: every bit gets a default before the loop so no path leaves e unassigned.
    e          = '0;
    e[N_SLOTS] = 1'b1;
    for (int j = 0; j < N_SLOTS; j++)
      e[j] = lap ? (j == int'(c)) : (j >= int'(c));
    return e;
  endfunction

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], btn[b]};
        prev_q[b] <= sync_q[b][SYNC_STAGES-1];
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      disp_sel_q    <= '0;
      mode_q        <= 1'b0;
      en_q          <= '0;
      running_q     <= '0;
      disp_update_q <= 1'b1;
      full_q        <= 1'b0;
    end else begin
      if (pause_e && state_q != IDLE)
        disp_update_q <= ~disp_update_q;

      case (state_q)
        IDLE: begin
          if (ss_e && !clear_e) begin
            mode_q     <= bus.mode;
            cur_q      <= '0;
            disp_sel_q <= '0;
            en_q       <= run_en('0, bus.mode);
            running_q  <= bus.mode ? LAP_START : SPLIT_START;
            state_q    <= RUN;
          end
        end

        RUN: begin
          if (clear_e) begin
            // clear has no effect while running but still masks the other buttons
          end else if (ss_e) begin
            en_q    <= '0;
            state_q <= STOP;
          end else if (mark_e && cur_q != LAST) begin
            for (int i = 0; i < N_SLOTS; i++) begin
              if (i == int'(cur_q))
                running_q[2*i +: 2] <= 2'b10;
              if (mode_q && i == int'(nxt_cur))
                running_q[2*i +: 2] <= 2'b01;
            end
            cur_q      <= nxt_cur;
            disp_sel_q <= nxt_cur;
            en_q       <= run_en(nxt_cur, mode_q);
            if (nxt_cur == LAST)
              full_q <= 1'b1;
          end
        end

        STOP: begin
          if (clear_e) begin
            // Overrides a same-cycle pause toggle: IDLE always shows live counters.
            state_q       <= IDLE;
            cur_q         <= '0;
            disp_sel_q    <= '0;
            mode_q        <= 1'b0;
            en_q          <= '0;
            running_q     <= '0;
            disp_update_q <= 1'b1;
            full_q        <= 1'b0;
          end else if (ss_e) begin
            en_q       <= run_en(cur_q, mode_q);
            disp_sel_q <= cur_q;
            state_q    <= RUN;
          end else if (mark_e) begin
            disp_sel_q <= (disp_sel_q == cur_q) ? '0 : disp_sel_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.en          = en_q;
  assign bus.running     = running_q;
  assign bus.disp_sel    = disp_sel_q;
  assign bus.disp_update = disp_update_q;
  assign bus.full        = full_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Randomised scoreboard bench for stopwatch_lap_ctrl: a slot-status reference model predicts
// every output snapshot; a negedge monitor retires predictions at their due cycle and compares continuously.
module tb_stopwatch_lap_ctrl;

  localparam int N    = 10;
  localparam int SELW = 4;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic n_reset;

  stopwatch_lap_ctrl_if #(.N_SLOTS(N), .SEL_W(SELW)) bus ();

  stopwatch_lap_ctrl #(.N_SLOTS(N), .SEL_W(SELW), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N:0]       en;
    logic [2*N-1:0]   running;
    logic [SELW-1:0]  disp_sel;
    logic             disp_update;
    logic             full;
  } snap_t;

  typedef struct {
    int    due;
    snap_t s;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_STOP} mstate_t;

  // Reference model: per-slot status 0 idle, 1 counting, 2 frozen.
  int      m_status [N];
  int      m_cur, m_sel;
  bit      m_lap, m_upd, m_full;
  mstate_t m_st;

  exp_t  q[$];
  snap_t exp_now;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_status[i] = 0;
    m_cur = 0; m_sel = 0; m_lap = 0; m_upd = 1; m_full = 0; m_st = M_IDLE;
  endfunction

  function automatic void model_event(input logic [3:0] b);
    if (b[0] && m_st != M_IDLE) m_upd = !m_upd;
    if (b[3]) begin
      if (m_st == M_STOP) model_reset();
    end else if (b[2]) begin
      case (m_st)
        M_IDLE: begin
          m_lap = bus.mode; m_cur = 0; m_sel = 0;
          for (int i = 0; i < N; i++) m_status[i] = (!m_lap || i == 0) ? 1 : 0;
          m_st = M_RUN;
        end
        M_RUN:  m_st = M_STOP;
        M_STOP: begin m_sel = m_cur; m_st = M_RUN; end
        default: ;
      endcase
    end else if (b[1]) begin
      if (m_st == M_RUN && m_cur < N - 1) begin
        m_status[m_cur] = 2;
        m_cur = m_cur + 1;
        m_sel = m_cur;
        if (m_lap) m_status[m_cur] = 1;
        if (m_cur == N - 1) m_full = 1;
      end else if (m_st == M_STOP) begin
        m_sel = (m_sel == m_cur) ? 0 : m_sel + 1;
      end
    end
  endfunction

  // A slot's enable is simply "it is counting and the watch is running".
  function automatic snap_t snap();
    snap_t s;
    s.en = '0;
    s.running = '0;
    for (int i = 0; i < N; i++) begin
      s.en[i] = (m_st == M_RUN) && (m_status[i] == 1);
      s.running[2*i +: 2] = 2'(m_status[i]);
    end
    s.en[N] = (m_st == M_RUN);
    s.disp_sel = SELW'(m_sel);
    s.disp_update = m_upd;
    s.full = m_full;
    return s;
  endfunction

  task automatic push_expect();
    exp_t e;
    e.due = cyc + 1 + SYNC;
    e.s = snap();
    q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) exp_now = q.pop_front().s;
    check("en", 64'(bus.en), 64'(exp_now.en));
    check("running", 64'(bus.running), 64'(exp_now.running));
    check("disp_sel", 64'(bus.disp_sel), 64'(exp_now.disp_sel));
    check("disp_update", 64'(bus.disp_update), 64'(exp_now.disp_update));
    check("full", 64'(bus.full), 64'(exp_now.full));
  end

  // b = {clear, startstop, mark, pause}; returns once the event has settled.
  task automatic press(input logic [3:0] b, input int hold, input int gap);
    @(negedge clk);
    bus.clear = b[3]; bus.startstop = b[2]; bus.mark = b[1]; bus.pause = b[0];
    model_event(b);
    push_expect();
    repeat (hold) @(negedge clk);
    bus.clear = 1'b0; bus.startstop = 1'b0; bus.mark = 1'b0; bus.pause = 1'b0;
    repeat (SYNC + 1 + gap) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0] b;
    int         r;
    logic [SELW-1:0] rev [6];
    rev[0] = 0; rev[1] = 1; rev[2] = 2; rev[3] = 3; rev[4] = 4; rev[5] = 0;

    n_reset = 1'b0;
    bus.startstop = 1'b0; bus.mark = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.mode = 1'b0;
    model_reset();
    exp_now = snap();
    repeat (3) @(negedge clk);
    check("rst_en", 64'(bus.en), 64'h0);
    check("rst_disp_update", 64'(bus.disp_update), 64'h1);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // SPLIT start: everything counting
    bus.mode = 1'b0;
    press(4'b0100, 1, 0);
    check("t1_en", 64'(bus.en), 64'h7FF);
    check("t1_running", 64'(bus.running), 64'h55555);
    check("t1_disp_sel", 64'(bus.disp_sel), 64'h0);

    // back to IDLE, then LAP start and three marks
    press(4'b0100, 2, 0);
    press(4'b1000, 1, 0);
    bus.mode = 1'b1;
    press(4'b0100, 1, 0);
    bus.mode = 1'b0;
    for (int i = 0; i < 3; i++) press(4'b0010, 1 + i, 0);
    check("t2_disp_sel", 64'(bus.disp_sel), 64'h3);
    check("t2_en", 64'(bus.en), 64'h408);
    check("t2_running", 64'(bus.running[7:0]), 64'h6A);

    // fill to the last slot, then extra (one long-held) marks change nothing
    for (int i = 0; i < 6; i++) press(4'b0010, 1, 0);
    check("t3_full", 64'(bus.full), 64'h1);
    press(4'b0010, 1, 0);
    press(4'b0010, 4, 1);
    check("t3_en", 64'(bus.en), 64'h600);
    check("t3_disp_sel", 64'(bus.disp_sel), 64'h9);

    // review in STOP at cur=4, then resume
    press(4'b0100, 1, 0);
    press(4'b1000, 1, 0);
    bus.mode = 1'b1;
    press(4'b0100, 1, 0);
    for (int i = 0; i < 4; i++) press(4'b0010, 1, 0);
    press(4'b0100, 1, 0);
    check("t4_stop_en", 64'(bus.en), 64'h0);
    for (int i = 0; i < 6; i++) begin
      press(4'b0010, 1, 0);
      check("t4_review_sel", 64'(bus.disp_sel), 64'(rev[i]));
    end
    press(4'b0100, 1, 0);
    check("t4_resume_en", 64'(bus.en), 64'h410);
    check("t4_resume_sel", 64'(bus.disp_sel), 64'h4);

    // simultaneous edges: startstop beats mark, clear beats startstop
    press(4'b0110, 1, 0);
    check("t5_stop_en", 64'(bus.en), 64'h0);
    check("t5_stop_sel", 64'(bus.disp_sel), 64'h4);
    press(4'b1100, 1, 0);
    check("t5_idle_running", 64'(bus.running), 64'h0);

    // pause toggling in RUN, then asynchronous reset mid-RUN
    bus.mode = 1'b0;
    press(4'b0100, 1, 0);
    press(4'b0001, 1, 0);
    check("t6_pause0", 64'(bus.disp_update), 64'h0);
    press(4'b0001, 3, 0);
    check("t6_pause1", 64'(bus.disp_update), 64'h1);
    press(4'b0001, 1, 0);
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("t6_rst_en", 64'(bus.en), 64'h0);
    check("t6_rst_running", 64'(bus.running), 64'h0);
    check("t6_rst_disp_update", 64'(bus.disp_update), 64'h1);
    q.delete();
    model_reset();
    exp_now = snap();

    // startstop held through reset fires once after release
    @(negedge clk);
    bus.mode = 1'b1;
    bus.startstop = 1'b1;
    @(negedge clk);
    n_reset = 1'b1;
    model_event(4'b0100);
    push_expect();
    repeat (3) @(negedge clk);
    bus.startstop = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    check("t6_held_en", 64'(bus.en), 64'h401);

    // randomised single-button traffic against the model
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30)      b = 4'b0100;
      else if (r < 65) b = 4'b0010;
      else if (r < 80) b = 4'b0001;
      else             b = 4'b1000;
      bus.mode = 1'($urandom_range(0, 1));
      press(b, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
